// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK / WS / frame-timing generator for I2S, left-justified and DSP/TDM framing.
// Optional feature: define I2S_CLKGEN_MCLK_EN to build the free-running mclk output.
module i2s_clkgen #(
  parameter int unsigned SLOT_BITS   = 24,
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned DIV_DEFAULT = 24,
  parameter int unsigned MCLK_DIV    = 4
) (
  input  logic                         clk_ref,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   fmt,
  input  logic [15:0]                  div_half,
  output logic                         bclk,
  output logic                         ws,
  output logic                         bclk_fall,
  output logic                         bclk_rise,
  output logic                         frame_start,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx
`ifdef I2S_CLKGEN_MCLK_EN
  ,
  output logic                         mclk
`endif
);

  localparam int unsigned SW = $clog2(NUM_SLOTS);
  localparam int unsigned BW = $clog2(SLOT_BITS);

  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
  localparam logic [SW-1:0] HALF_SLOT = SW'(NUM_SLOTS / 2);
  localparam logic [BW-1:0] TOP_BIT   = BW'(SLOT_BITS - 1);
  localparam logic [15:0]   DIV_RST   = (DIV_DEFAULT == 0) ? 16'd1 : 16'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    FMT_I2S  = 2'd0,
    FMT_LJ   = 2'd1,
    FMT_DSP  = 2'd2,
    FMT_RSVD = 2'd3
  } fmt_e;

  if (SLOT_BITS < 2 || SLOT_BITS > 32 || NUM_SLOTS < 2 || NUM_SLOTS > 16 ||
      (NUM_SLOTS % 2) != 0 || MCLK_DIV < 1) begin : g_param_check
    $error("i2s_clkgen: parameter out of range");
  end

  logic [15:0]   ph_q, ph_d;
  logic [15:0]   div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          ws_q, ws_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          fs_q, fs_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] nxt_slot;

  always_comb begin
    ph_d     = ph_q;
    div_d    = div_q;
    bclk_d   = bclk_q;
    ws_d     = ws_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    fs_d     = 1'b0;
    slot_d   = slot_q;
    bit_d    = bit_q;
    nxt_slot = '0;

    if (!en) begin
      // Position and divider are frozen; the phase restarts so resume begins a fresh half-period.
      ph_d   = '0;
      bclk_d = 1'b0;
      ws_d   = 1'b0;
    end else if (ph_q == div_q - 16'd1) begin
      ph_d   = '0;
      bclk_d = ~bclk_q;
      if (!bclk_q) begin
        rise_d = 1'b1;
      end else begin
        fall_d = 1'b1;
        if (bit_q == '0) begin
          bit_d = TOP_BIT;
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            fs_d   = 1'b1;
            div_d  = (div_half == 16'd0) ? 16'd1 : div_half;
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end else begin
          bit_d = bit_q - BW'(1);
        end

        // ws is registered alongside the new position; I2S looks one bit ahead.
        if (bit_d == '0) nxt_slot = (slot_d == LAST_SLOT) ? '0 : slot_d + SW'(1);
        else             nxt_slot = slot_d;

        case (fmt_e'(fmt))
          FMT_LJ:  ws_d = (slot_d < HALF_SLOT);
          FMT_DSP: ws_d = (slot_d == LAST_SLOT) && (bit_d == '0);
          default: ws_d = (nxt_slot >= HALF_SLOT);
        endcase
      end
    end else begin
      ph_d = ph_q + 16'd1;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      ph_q   <= '0;
      div_q  <= DIV_RST;
      bclk_q <= 1'b0;
      ws_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fs_q   <= 1'b0;
      slot_q <= LAST_SLOT;
      bit_q  <= '0;
    end else begin
      ph_q   <= ph_d;
      div_q  <= div_d;
      bclk_q <= bclk_d;
      ws_q   <= ws_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      fs_q   <= fs_d;
      slot_q <= slot_d;
      bit_q  <= bit_d;
    end
  end

  assign bclk        = bclk_q;
  assign ws          = ws_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign slot_idx    = slot_q;
  assign bit_idx     = bit_q;

`ifdef I2S_CLKGEN_MCLK_EN
  localparam logic [15:0] MCLK_LAST = 16'(MCLK_DIV - 1);

  logic [15:0] mcnt_q, mcnt_d;
  logic        mclk_q, mclk_d;

  always_comb begin
    mcnt_d = mcnt_q + 16'd1;
    mclk_d = mclk_q;
    if (mcnt_q == MCLK_LAST) begin
      mcnt_d = '0;
      mclk_d = ~mclk_q;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      mcnt_q <= '0;
      mclk_q <= 1'b0;
    end else begin
      mcnt_q <= mcnt_d;
      mclk_q <= mclk_d;
    end
  end

  assign mclk = mclk_q;
`endif

endmodule

// File: tb/tb_i2s_clkgen.sv
// Self-checking bench for i2s_clkgen: two instances (2-slot and 8-slot) against a bit-count reference model.
module tb_i2s_clkgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en;
  logic [1:0]  fmt;
  logic [15:0] div_half;

  logic       bclk_a, ws_a, rise_a, fall_a, fs_a;
  logic [0:0] slot_a;
  logic [1:0] bit_a;
  logic       bclk_b, ws_b, rise_b, fall_b, fs_b;
  logic [2:0] slot_b;
  logic [1:0] bit_b;
`ifdef I2S_CLKGEN_MCLK_EN
  logic       mclk_a, mclk_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  i2s_clkgen #(.SLOT_BITS(4), .NUM_SLOTS(2), .DIV_DEFAULT(2), .MCLK_DIV(4)) dut_a (
    .clk_ref(clk), .reset(reset), .en(en), .fmt(fmt), .div_half(div_half),
    .bclk(bclk_a), .ws(ws_a), .bclk_fall(fall_a), .bclk_rise(rise_a),
    .frame_start(fs_a), .slot_idx(slot_a), .bit_idx(bit_a)
`ifdef I2S_CLKGEN_MCLK_EN
    , .mclk(mclk_a)
`endif
  );

  i2s_clkgen #(.SLOT_BITS(4), .NUM_SLOTS(8), .DIV_DEFAULT(5), .MCLK_DIV(4)) dut_b (
    .clk_ref(clk), .reset(reset), .en(en), .fmt(fmt), .div_half(div_half),
    .bclk(bclk_b), .ws(ws_b), .bclk_fall(fall_b), .bclk_rise(rise_b),
    .frame_start(fs_b), .slot_idx(slot_b), .bit_idx(bit_b)
`ifdef I2S_CLKGEN_MCLK_EN
    , .mclk(mclk_b)
`endif
  );

  // Reference model: position is a flat bit count within the frame (0 = slot 0 MSB).
  typedef struct {
    int gpos;
    int tcnt;
    int div;
    bit bclk;
    bit ws;
    bit rise;
    bit fall;
    bit fs;
  } mst_t;

  function automatic mst_t mstep(mst_t s, int sb, int ns, int dflt,
                                 bit rst, bit en_i, logic [1:0] fmt_i, int dh);
    mst_t n = s;
    int frame = sb * ns;
    n.rise = 0; n.fall = 0; n.fs = 0;
    if (rst) begin
      n.gpos = frame - 1; n.tcnt = 0; n.div = (dflt < 1) ? 1 : dflt;
      n.bclk = 0; n.ws = 0;
    end else if (!en_i) begin
      n.tcnt = 0; n.bclk = 0; n.ws = 0;
    end else begin
      n.tcnt = s.tcnt + 1;
      if (n.tcnt == s.div) begin
        n.tcnt = 0;
        n.bclk = !s.bclk;
        if (n.bclk) n.rise = 1;
        else begin
          n.fall = 1;
          n.gpos = (s.gpos + 1) % frame;
          if (n.gpos == 0) begin
            n.fs  = 1;
            n.div = (dh < 1) ? 1 : dh;
          end
          case (fmt_i)
            2'd1:    n.ws = (n.gpos / sb) < (ns / 2);
            2'd2:    n.ws = (n.gpos == frame - 1);
            default: n.ws = (((n.gpos + 1) % frame) / sb) >= (ns / 2);
          endcase
        end
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] pk(logic bc, logic w, logic r, logic f, logic s,
                                     logic [2:0] sl, logic [4:0] bt);
    return {bc, w, r, f, s, sl, bt};
  endfunction

  mst_t ma, mb;
  always @(posedge clk) begin
    ma <= mstep(ma, 4, 2, 2, reset, en, fmt, int'(div_half));
    mb <= mstep(mb, 4, 8, 5, reset, en, fmt, int'(div_half));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; fmt = 2'd0; div_half = 16'd2;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; fmt = 2'd0; div_half = 16'd2;
    repeat (4) tick();
    n_tests++;
    if ({bclk_a, ws_a, rise_a, fall_a, fs_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_out_a: got %b want 00000", {bclk_a, ws_a, rise_a, fall_a, fs_a});
    end
    n_tests++;
    if ({bclk_b, ws_b, rise_b, fall_b, fs_b} !== 5'b0) begin
      n_fail++; $display("FAIL reset_out_b: got %b want 00000", {bclk_b, ws_b, rise_b, fall_b, fs_b});
    end
    n_tests++;
    if (slot_a !== 1'd1 || bit_a !== 2'd0) begin
      n_fail++; $display("FAIL reset_pos_a: got slot %0d bit %0d want slot 1 bit 0", slot_a, bit_a);
    end
    n_tests++;
    if (slot_b !== 3'd7 || bit_b !== 2'd0) begin
      n_fail++; $display("FAIL reset_pos_b: got slot %0d bit %0d want slot 7 bit 0", slot_b, bit_b);
    end
    reset = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_i2s_startup();
    int fr_a = -1, ff_a = -1, fr_b = -1, ff_b = -1;
    int last_rise = -1, last_fs = -1, ws_rises = 0;
    logic ws_prev = 1'b0;
    do_reset();
    fmt = 2'd0; div_half = 16'd2; en = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (rise_a) begin
        if (fr_a < 0) fr_a = c;
        else begin
          n_tests++;
          if (c - last_rise != 4) begin
            n_fail++; $display("FAIL i2s_bclk_period: got %0d want 4", c - last_rise);
          end
        end
        last_rise = c;
      end
      if (fs_a) begin
        if (ff_a < 0) ff_a = c;
        else begin
          n_tests++;
          if (c - last_fs != 32) begin
            n_fail++; $display("FAIL i2s_frame_period: got %0d want 32", c - last_fs);
          end
        end
        last_fs = c;
      end
      if (rise_b && fr_b < 0) fr_b = c;
      if (fs_b && ff_b < 0) ff_b = c;
      if (ws_a && !ws_prev) begin
        ws_rises++;
        n_tests++;
        if (fall_a !== 1'b1 || slot_a !== 1'd0 || bit_a !== 2'd0) begin
          n_fail++; $display("FAIL i2s_ws_rise_pos: got fall %b slot %0d bit %0d want 1/0/0", fall_a, slot_a, bit_a);
        end
      end
      ws_prev = ws_a;
    end
    n_tests++;
    if (fr_a != 2) begin n_fail++; $display("FAIL i2s_first_rise_a: got %0d want 2", fr_a); end
    n_tests++;
    if (ff_a != 4) begin n_fail++; $display("FAIL i2s_first_fs_a: got %0d want 4", ff_a); end
    n_tests++;
    if (fr_b != 5) begin n_fail++; $display("FAIL i2s_first_rise_b: got %0d want 5", fr_b); end
    n_tests++;
    if (ff_b != 10) begin n_fail++; $display("FAIL i2s_first_fs_b: got %0d want 10", ff_b); end
    n_tests++;
    if (ws_rises != 3) begin n_fail++; $display("FAIL i2s_ws_rise_count: got %0d want 3", ws_rises); end
  endtask

  task automatic test_lj();
    int streak = 0, n_win = 0;
    do_reset();
    fmt = 2'd1; div_half = 16'd2; en = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      n_tests++;
      if (ws_a !== (slot_a == 1'd0)) begin
        n_fail++; $display("FAIL lj_ws_level: cycle %0d got ws %b slot %0d", c, ws_a, slot_a);
      end
      if (ws_a) streak++;
      else if (streak > 0) begin
        n_win++;
        n_tests++;
        if (streak != 16) begin n_fail++; $display("FAIL lj_ws_width: got %0d want 16", streak); end
        streak = 0;
      end
    end
    n_tests++;
    if (n_win != 3) begin n_fail++; $display("FAIL lj_window_count: got %0d want 3", n_win); end
  endtask

  task automatic test_dsp();
    int streak = 0, nfs = 0, n_win = 0, exp_slot = 0;
    logic ws_prev = 1'b0;
    do_reset();
    fmt = 2'd2; div_half = 16'd2; en = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (fs_b) begin
        n_tests++;
        if ((nfs == 0) ? (streak != 0) : (streak != 4)) begin
          n_fail++; $display("FAIL dsp_pulse_len: frame %0d got %0d want %0d", nfs, streak, (nfs == 0) ? 0 : 4);
        end
        nfs++;
      end
      if (ws_prev && !ws_b) begin
        n_win++;
        n_tests++;
        if (fs_b !== 1'b1) begin n_fail++; $display("FAIL dsp_pulse_end: got fs %b want 1", fs_b); end
      end
      n_tests++;
      if ((nfs == 0) ? (ws_b !== 1'b0) : (ws_b !== ((slot_b == 3'd7) && (bit_b == 2'd0)))) begin
        n_fail++; $display("FAIL dsp_ws_level: cycle %0d got ws %b slot %0d bit %0d", c, ws_b, slot_b, bit_b);
      end
      if (fall_b && bit_b == 2'd3) begin
        n_tests++;
        if (slot_b !== 3'(exp_slot)) begin
          n_fail++; $display("FAIL dsp_slot_seq: got %0d want %0d", slot_b, exp_slot);
        end
        exp_slot = (exp_slot + 1) % 8;
      end
      streak  = ws_b ? streak + 1 : 0;
      ws_prev = ws_b;
    end
    n_tests++;
    if (nfs != 4 || n_win != 3) begin
      n_fail++; $display("FAIL dsp_counts: got fs %0d pulses %0d want 4 and 3", nfs, n_win);
    end
  endtask

  task automatic test_div_change();
    int chg = -1, fs_new = -1, last_rise = -1, last_fs = -1, n6 = 0, n48 = 0;
    do_reset();
    fmt = 2'd0; div_half = 16'd2; en = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      tick();
      if (rise_a) begin
        if (last_rise >= 0) begin
          if (fs_new < 0) begin
            n_tests++;
            if (c - last_rise != 4) begin n_fail++; $display("FAIL div_old_period: got %0d want 4", c - last_rise); end
          end else if (last_rise > fs_new) begin
            n_tests++; n6++;
            if (c - last_rise != 6) begin n_fail++; $display("FAIL div_new_period: got %0d want 6", c - last_rise); end
          end
        end
        last_rise = c;
      end
      if (fs_a) begin
        if (chg >= 0 && fs_new < 0) fs_new = c;
        else if (fs_new >= 0) begin
          n_tests++; n48++;
          if (c - last_fs != 48) begin n_fail++; $display("FAIL div_frame_len: got %0d want 48", c - last_fs); end
        end
        last_fs = c;
      end
      if (c == 14) begin div_half = 16'd3; chg = c; end
    end
    n_tests++;
    if (fs_new != 36 || n48 != 2 || n6 < 10) begin
      n_fail++; $display("FAIL div_switch_point: got fs %0d frames %0d periods %0d want 36, 2, >=10", fs_new, n48, n6);
    end
    div_half = 16'd2;
  endtask

  task automatic test_div_zero();
    int last_fs = -1, n16 = 0;
    do_reset();
    fmt = 2'd0; div_half = 16'd0; en = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (fs_a) begin
        if (last_fs >= 0) begin
          n_tests++; n16++;
          if (c - last_fs != 16) begin n_fail++; $display("FAIL div0_frame_len: got %0d want 16", c - last_fs); end
        end
        last_fs = c;
      end
    end
    n_tests++;
    if (n16 != 3) begin n_fail++; $display("FAIL div0_frame_count: got %0d want 3", n16); end
    div_half = 16'd2;
  endtask

  task automatic test_en_pause();
    logic [0:0] hs;
    logic [1:0] hb;
    int es, eb, resume_fall = -1;
    do_reset();
    fmt = 2'd1; div_half = 16'd2; en = 1'b1;
    repeat (13) tick();
    hs = slot_a; hb = bit_a;
    en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_tests++;
      if ({bclk_a, ws_a, rise_a, fall_a, fs_a, bclk_b, ws_b} !== 7'b0 || slot_a !== hs || bit_a !== hb) begin
        n_fail++;
        $display("FAIL pause_hold: got out %b slot %0d bit %0d want 0000000 slot %0d bit %0d",
                 {bclk_a, ws_a, rise_a, fall_a, fs_a, bclk_b, ws_b}, slot_a, bit_a, hs, hb);
      end
    end
    es = int'(hs); eb = int'(hb);
    if (eb == 0) begin eb = 3; es = (es + 1) % 2; end
    else eb--;
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_tests++;
      if (pk(bclk_a, ws_a, rise_a, fall_a, fs_a, 3'(slot_a), 5'(bit_a)) !==
          pk(ma.bclk, ma.ws, ma.rise, ma.fall, ma.fs, 3'(ma.gpos / 4), 5'(3 - ma.gpos % 4))) begin
        n_fail++; $display("FAIL pause_resume_model: cycle %0d got %b", c,
                           pk(bclk_a, ws_a, rise_a, fall_a, fs_a, 3'(slot_a), 5'(bit_a)));
      end
      if (fall_a && resume_fall < 0) begin
        resume_fall = c;
        n_tests++;
        if (slot_a !== 1'(es) || bit_a !== 2'(eb)) begin
          n_fail++; $display("FAIL pause_resume_pos: got slot %0d bit %0d want slot %0d bit %0d", slot_a, bit_a, es, eb);
        end
      end
    end
    n_tests++;
    if (resume_fall != 4) begin n_fail++; $display("FAIL pause_resume_time: got %0d want 4", resume_fall); end
  endtask

  task automatic test_random();
    int pause = 0;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) fmt = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) div_half = 16'($urandom_range(4));
      if (pause > 0) begin
        pause--;
        if (pause == 0) en = 1'b1;
      end else if ($urandom_range(79) == 0) begin
        en = 1'b0; pause = int'($urandom_range(12, 1));
      end
      reset = ($urandom_range(699) == 0);
      tick();
      n_tests++;
      if (pk(bclk_a, ws_a, rise_a, fall_a, fs_a, 3'(slot_a), 5'(bit_a)) !==
          pk(ma.bclk, ma.ws, ma.rise, ma.fall, ma.fs, 3'(ma.gpos / 4), 5'(3 - ma.gpos % 4))) begin
        n_fail++; $display("FAIL rand_model_a: cycle %0d got %b want %b", c,
                           pk(bclk_a, ws_a, rise_a, fall_a, fs_a, 3'(slot_a), 5'(bit_a)),
                           pk(ma.bclk, ma.ws, ma.rise, ma.fall, ma.fs, 3'(ma.gpos / 4), 5'(3 - ma.gpos % 4)));
      end
      n_tests++;
      if (pk(bclk_b, ws_b, rise_b, fall_b, fs_b, slot_b, 5'(bit_b)) !==
          pk(mb.bclk, mb.ws, mb.rise, mb.fall, mb.fs, 3'(mb.gpos / 4), 5'(3 - mb.gpos % 4))) begin
        n_fail++; $display("FAIL rand_model_b: cycle %0d got %b want %b", c,
                           pk(bclk_b, ws_b, rise_b, fall_b, fs_b, slot_b, 5'(bit_b)),
                           pk(mb.bclk, mb.ws, mb.rise, mb.fall, mb.fs, 3'(mb.gpos / 4), 5'(3 - mb.gpos % 4)));
      end
    end
    reset = 1'b0;
  endtask

`ifdef I2S_CLKGEN_MCLK_EN
  task automatic test_mclk();
    reset = 1'b1; en = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (mclk_a !== 1'b0 || mclk_b !== 1'b0) begin
      n_fail++; $display("FAIL mclk_reset: got %b%b want 00", mclk_a, mclk_b);
    end
    reset = 1'b0;
    for (int c = 1; c <= 56; c++) begin
      if (c == 41) en = 1'b1;
      tick();
      n_tests++;
      if (mclk_a !== 1'((c / 4) % 2) || mclk_b !== 1'((c / 4) % 2)) begin
        n_fail++; $display("FAIL mclk_wave: cycle %0d got %b%b want %0d", c, mclk_a, mclk_b, (c / 4) % 2);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b0; fmt = 2'd0; div_half = 16'd2;
    @(negedge clk);
    test_reset();
    test_i2s_startup();
    test_lj();
    test_dsp();
    test_div_change();
    test_div_zero();
    test_en_pause();
    test_random();
`ifdef I2S_CLKGEN_MCLK_EN
    test_mclk();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_clkgen.md
# i2s_clkgen

Parametrised I2S/TDM serial-clock and frame-timing generator, clocked from the 100 MHz fabric reference. It produces BCLK and WS for 2-channel I2S, left-justified, or multi-slot DSP/TDM framing. It also produces single-cycle strobes and the slot/bit position that the serializer and deserializer consume. The divider can be changed at run time, and a new value takes effect only on a frame boundary, so sample-rate switches are glitch-free.

## Interface
- `SLOT_BITS`, default 24: bits per slot, 2..32.
- `NUM_SLOTS`, default 2: slots per frame, even, 2..16.
- `DIV_DEFAULT`, default 24: reset value of the BCLK half-period, in clk_ref cycles.
- `MCLK_DIV`, default 4: MCLK half-period in clk_ref cycles. Used only with the macro.
- `clk_ref` input, 1 bit: reference clock. All logic is on its rising edge.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `en` input, 1 bit: run enable.
- `fmt` input, 2 bits: 0 = I2S, 1 = left-justified, 2 = DSP/TDM, 3 = reserved (treated as 0).
- `div_half` input, 16 bits: requested BCLK half-period; 0 is treated as 1.
- `bclk` output, 1 bit: bit clock.
- `ws` output, 1 bit: word select / frame sync.
- `bclk_fall` output, 1 bit: one-cycle strobe, high in the cycle bclk goes 1→0.
- `bclk_rise` output, 1 bit: one-cycle strobe, high in the cycle bclk goes 0→1.
- `frame_start` output, 1 bit: one-cycle strobe on the bclk_fall that enters slot 0, bit SLOT_BITS-1.
- `slot_idx` output, $clog2(NUM_SLOTS) bits: slot currently driven.
- `bit_idx` output, $clog2(SLOT_BITS) bits: bit currently driven, MSB first.
- `mclk` output, 1 bit: master clock. Present only with the macro.

## Operation
- Internal state:
  - 16-bit phase counter `ph`.
  - Latched divider `div_q`.
  - Position (slot_idx, bit_idx): the bit on the data line from one falling BCLK edge to the next.
- Reset:
  - ph=0, div_q=max(DIV_DEFAULT,1).
  - bclk=0, ws=0, all strobes 0.
  - Position = last bit of frame: slot NUM_SLOTS-1, bit 0.
- en=0: every register holds its value except bclk, ws and the strobes, which are forced 0. Deasserting en mid-frame freezes the position. Reasserting en resumes from it with ph restarted at 0.
- en=1: ph counts up each cycle. When ph==div_q-1:
  - ph←0.
  - bclk toggles.
  - The matching strobe pulses in the same cycle.
- Position update, on each falling edge:
  - bit_idx decrements.
  - At 0, bit_idx wraps to SLOT_BITS-1 and slot_idx increments.
  - slot_idx wraps from NUM_SLOTS-1 to 0; this wrap asserts frame_start and loads div_q←max(div_half,1).
- ws is updated only on falling edges and is registered with the new position. With p = new position and p+1 = its successor:
  - fmt 0 (I2S): ws = slot(p+1) ≥ NUM_SLOTS/2, so WS leads the MSB by one BCLK.
  - fmt 1 (LJ): ws = slot(p) < NUM_SLOTS/2.
  - fmt 2 (DSP): ws = 1 iff p is slot NUM_SLOTS-1, bit 0, i.e. a one-BCLK pulse before each frame. The first frame after reset or enable has no leading pulse.
- `fmt` is sampled at every falling edge. Changing it mid-frame is legal; it affects ws from the next falling edge.

## Timing
- BCLK frequency = f_ref / (2·div_q).
- Frame length = 2·div_q·SLOT_BITS·NUM_SLOTS clk_ref cycles.
- Startup: the first falling edge, which is also the first frame_start, occurs 2·div_q cycles after the first cycle with en=1.
- bclk, ws, strobes and position all change in the same clk_ref cycle, with zero skew among them. Consumers shift data on bclk_fall and sample on bclk_rise.
- A div_half change is invisible until the next frame_start. The new period applies starting with the rising edge that follows that frame_start.
- If reset and a toggle occur in the same cycle, reset wins.

## Configuration
- `I2S_CLKGEN_MCLK_EN` defined:
  - `mclk` port exists.
  - mclk toggles every MCLK_DIV clk_ref cycles, independent of en.
  - Reset to 0; it has its own counter and is not phase-locked to bclk.
- Not defined: the `mclk` port and its logic are absent.

## Test plan
- Reset, SLOT_BITS=4, NUM_SLOTS=2, div_half=2, fmt=0, then en=1:
  - first bclk_rise at cycle 2, first frame_start at cycle 4.
  - bclk period 4, frame_start every 32 cycles.
  - ws rises on the falling edge at slot 0, bit 0.
- Same setup with fmt=1: ws=1 exactly during slot 0 (16 cycles), 0 during slot 1.
- fmt=2, NUM_SLOTS=8: ws is a single 4-cycle high window ending at each frame_start, starting from the second frame; slot_idx sequence is 0..7.
- Change div_half from 2 to 3 mid-frame: the period stays 4 until the next frame_start, then becomes 6; a frame spans 48 cycles.
- Drop en for 10 cycles mid-slot: bclk and ws are held 0, position is frozen, and output resumes from the same bit_idx.
- With the macro defined and MCLK_DIV=4: mclk period is 8 cycles during reset release and with en=0.
